// File: rtl/pattern_rx.sv
// Serial "101" pattern receiver: a pattern is accepted only after a run of at
// least QUIET_MIN idle (low) samples, and is then held until acknowledged.
module pattern_rx #(
  parameter int QUIET_MIN = 6,
  parameter int CNT_BITS  = 8
) (
  input  logic                in_clk,
  input  logic                in_rst,
  input  logic                in_enable,
  input  logic                in_data,
  input  logic                in_ack,
  output logic                out_valid,
  output logic                out_err,
  output logic                out_busy,
  output logic [CNT_BITS-1:0] out_count,
  output logic [2:0]          out_state
);

  typedef enum logic [2:0] {
    ST_QUIET    = 3'd0,
    ST_GOT_ONE  = 3'd1,
    ST_GOT_ZERO = 3'd2,
    ST_VALID    = 3'd3
  } state_e;

  localparam logic [7:0] QMIN = 8'(QUIET_MIN);

  state_e              state_q, state_d;
  logic [7:0]          qctr_q, qctr_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [CNT_BITS-1:0] count_q, count_d;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    qctr_d  = qctr_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    count_d = count_q;

    unique case (state_q)
      ST_QUIET: begin
        if (!in_enable) begin
          qctr_d = 8'd0;
        end else if (!in_data) begin
          qctr_d = (qctr_q == QMIN) ? qctr_q : qctr_q + 8'd1;
        end else if (qctr_q == QMIN) begin
          state_d = ST_GOT_ONE;
          qctr_d  = 8'd0;
        end else begin
          qctr_d = 8'd0;
        end
      end

      ST_GOT_ONE: begin
        if (!in_enable) begin
          state_d = ST_QUIET;
          qctr_d  = 8'd0;
        end else if (!in_data) begin
          state_d = ST_GOT_ZERO;
        end else begin
          state_d = ST_QUIET;
          qctr_d  = 8'd0;
          err_d   = 1'b1;
        end
      end

      ST_GOT_ZERO: begin
        if (!in_enable) begin
          state_d = ST_QUIET;
          qctr_d  = 8'd0;
        end else if (in_data) begin
          state_d = ST_VALID;
          valid_d = 1'b1;
          if (count_q != '1) count_d = count_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
          // The mismatching zero is itself the first sample of a new quiet run.
          state_d = ST_QUIET;
          qctr_d  = 8'd1;
          err_d   = 1'b1;
        end
      end

      ST_VALID: begin
        if (in_ack) begin
          state_d = ST_QUIET;
          qctr_d  = 8'd0;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_QUIET;
        qctr_d  = 8'd0;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_GOT_ONE) || (state_d == ST_GOT_ZERO);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_QUIET;
      qctr_q  <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      qctr_q  <= qctr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign out_valid = valid_q;
  assign out_err   = err_q;
  assign out_busy  = busy_q;
  assign out_count = count_q;
  assign out_state = state_q;

endmodule

// File: tb/tb_pattern_rx.sv
// Self-checking bench for pattern_rx: a vector table, directed corner cases and
// random traffic, all compared against a queue-based reference model.
module tb_pattern_rx;

  localparam int QMIN = 6;

  logic       clk = 1'b0;
  logic       rst, en, data, ack;
  logic       v1, e1, b1, v2, e2, b2;
  logic [7:0] c1;
  logic [1:0] c2;
  logic [2:0] s1, s2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pattern_rx #(.QUIET_MIN(QMIN), .CNT_BITS(8)) dut (
    .in_clk(clk), .in_rst(rst), .in_enable(en), .in_data(data), .in_ack(ack),
    .out_valid(v1), .out_err(e1), .out_busy(b1), .out_count(c1), .out_state(s1)
  );

  pattern_rx #(.QUIET_MIN(QMIN), .CNT_BITS(2)) dut2 (
    .in_clk(clk), .in_rst(rst), .in_enable(en), .in_data(data), .in_ack(ack),
    .out_valid(v2), .out_err(e2), .out_busy(b2), .out_count(c2), .out_state(s2)
  );

  // Reference model: unbounded idle-run length plus the list of pattern bits seen so far.
  int unsigned m_zero_run;
  bit          m_pat[$];
  bit          m_valid, m_err;
  int unsigned m_cnt;
  bit          want [3] = '{1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit d, input bit a);
    m_err = 1'b0;
    if (r) begin
      m_zero_run = 0; m_pat.delete(); m_valid = 1'b0; m_cnt = 0;
    end else if (m_valid) begin
      if (a) begin m_valid = 1'b0; m_zero_run = 0; end
    end else if (!e) begin
      m_pat.delete(); m_zero_run = 0;
    end else if (m_pat.size() == 0) begin
      if (!d) m_zero_run++;
      else begin
        if (m_zero_run >= QMIN) m_pat.push_back(1'b1);
        m_zero_run = 0;
      end
    end else if (d == want[m_pat.size()]) begin
      m_pat.push_back(d);
      if (m_pat.size() == 3) begin
        m_valid = 1'b1; m_cnt++; m_pat.delete(); m_zero_run = 0;
      end
    end else begin
      m_err = 1'b1; m_pat.delete(); m_zero_run = d ? 0 : 1;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit d, input bit a);
    int unsigned st;
    rst = r; en = e; data = d; ack = a;
    @(posedge clk);
    model_step(r, e, d, a);
    #1;
    st = m_valid ? 3 : m_pat.size();
    check("valid", v1, m_valid);
    check("err",   e1, m_err);
    check("busy",  b1, !m_valid && m_pat.size() != 0);
    check("state", s1, st);
    check("count", c1, (m_cnt > 255) ? 255 : m_cnt);
    check("count_w2", c2, (m_cnt > 3) ? 3 : m_cnt);
    check("valid_w2", v2, m_valid);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  task automatic pattern_acked();
    zeros(QMIN); step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 0); step(0, 1, 0, 1);
  endtask

  typedef struct {
    bit r, e, d, a;
    bit valid, err, busy;
    int unsigned state, count;
  } vec_t;

  initial begin
    vec_t vecs[$];
    rst = 1'b1; en = 1'b0; data = 1'b0; ack = 1'b0;
    m_zero_run = 0; m_valid = 0; m_err = 0; m_cnt = 0;

    // Basic accepted pattern with ack, expectations written out by hand.
    vecs.push_back('{1,0,0,0, 0,0,0, 0,0});
    for (int i = 0; i < QMIN; i++) vecs.push_back('{0,1,0,0, 0,0,0, 0,0});
    vecs.push_back('{0,1,1,0, 0,0,1, 1,0});
    vecs.push_back('{0,1,0,0, 0,0,1, 2,0});
    vecs.push_back('{0,1,1,0, 1,0,0, 3,1});
    vecs.push_back('{0,1,0,0, 1,0,0, 3,1});
    vecs.push_back('{0,1,0,1, 0,0,0, 0,1});
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].e, vecs[i].d, vecs[i].a);
      check("tbl_valid", v1, vecs[i].valid);
      check("tbl_err",   e1, vecs[i].err);
      check("tbl_busy",  b1, vecs[i].busy);
      check("tbl_state", s1, vecs[i].state);
      check("tbl_count", c1, vecs[i].count);
    end

    // Too-short quiet run: pattern ignored, no error.
    step(1, 1, 0, 0);
    zeros(QMIN - 1); step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
    check("short_valid", v1, 0); check("short_err", e1, 0); check("short_count", c1, 0);

    // "11" mismatch: single-cycle error pulse, back to Quiet.
    zeros(QMIN); step(0, 1, 1, 0); step(0, 1, 1, 0);
    check("m11_err", e1, 1); check("m11_state", s1, 0);
    step(0, 1, 0, 0);
    check("m11_err_clear", e1, 0);

    // "100" mismatch: offending zero counts as quiet, so QUIET_MIN-1 more suffice.
    step(1, 1, 0, 0);
    zeros(QMIN); step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
    check("m100_err", e1, 1);
    zeros(QMIN - 1); step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
    check("m100_recover", v1, 1);
    step(0, 1, 0, 1);

    // Valid held against data toggles and disable; ack completes; second count.
    step(1, 1, 0, 0);
    zeros(QMIN); step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
    step(0, 1, 1, 0); step(0, 0, 0, 0); step(0, 1, 1, 0);
    check("hold_valid", v1, 1); check("hold_state", s1, 3);
    step(0, 0, 0, 1);
    check("ack_clear", v1, 0);
    pattern_acked();
    check("second_count", c1, 2);

    // Ack with no valid pending does nothing harmful.
    zeros(QMIN); step(0, 1, 1, 1);
    check("ack_ignored_state", s1, 1);

    // Saturating narrow counter.
    step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) pattern_acked();
    check("sat_w2", c2, 3); check("wide_5", c1, 5);

    // Reset in GotZero clears everything immediately.
    zeros(QMIN); step(0, 1, 1, 0); step(0, 1, 0, 0);
    check("pre_rst_state", s1, 2);
    step(1, 1, 1, 1);
    check("rst_state", s1, 0); check("rst_busy", b1, 0); check("rst_count", c1, 0);
    check("rst_valid", v1, 0); check("rst_err", e1, 0);

    // Disable in GotOne: Quiet, no error.
    zeros(QMIN); step(0, 1, 1, 0); step(0, 0, 1, 0);
    check("dis_state", s1, 0); check("dis_err", e1, 0);

    // Long quiet run must not wrap the quiet counter.
    zeros(300); step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
    check("long_quiet_valid", v1, 1);
    step(0, 1, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++)
      step($urandom_range(199) == 0, $urandom_range(15) != 0,
           $urandom_range(3) == 0, $urandom_range(3) == 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pattern_rx.md
PATTERN_RX -- requirements
Module: pattern_rx

Interface
REQ-001 SHALL have parameter QUIET_MIN, default 6, meaning the minimum number of consecutive low samples required before a pattern is accepted (legal range 1..255).
REQ-002 SHALL have parameter CNT_BITS, default 8, meaning the width of the match counter.
REQ-003 SHALL have port in_clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port in_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_enable, input, 1 bit: receiver enable.
REQ-006 SHALL have port in_data, input, 1 bit: serial line, sampled once per clock.
REQ-007 SHALL have port in_ack, input, 1 bit: consumer acknowledge for out_valid.
REQ-008 SHALL have port out_valid, output, 1 bit: pattern detected; held until acknowledged.
REQ-009 SHALL have port out_err, output, 1 bit: one-cycle pulse on a pattern mismatch.
REQ-010 SHALL have port out_busy, output, 1 bit: high while the block is mid-pattern.
REQ-011 SHALL have port out_count, output, CNT_BITS bits: saturating count of accepted patterns.
REQ-012 SHALL have port out_state, output, 3 bits: state encoding for debug (Quiet=0, GotOne=1, GotZero=2, Valid=3).
REQ-013 SHALL drive every output from a register, with no combinational path from any input to any output.

Function
REQ-014 SHALL implement states Quiet, GotOne, GotZero and Valid, plus a quiet counter qctr that saturates at QUIET_MIN.
REQ-015 In Quiet, in_data=0 SHALL increment qctr, saturating at QUIET_MIN.
REQ-016 In Quiet, in_data=1 with qctr==QUIET_MIN SHALL move to GotOne and clear qctr.
REQ-017 In Quiet, in_data=1 with qctr<QUIET_MIN SHALL clear qctr, stay in Quiet and raise no error.
REQ-018 In GotOne, in_data=0 SHALL move to GotZero.
REQ-019 In GotOne, in_data=1 SHALL be a mismatch: go to Quiet with qctr=0.
REQ-020 In GotZero, in_data=1 SHALL move to Valid, set out_valid=1 and increment out_count, saturating at all-ones.
REQ-021 In GotZero, in_data=0 SHALL be a mismatch: go to Quiet with qctr=1, because the mismatching zero counts as quiet.
REQ-022 On a mismatch, out_err SHALL be 1 for exactly the cycle after the offending sample, then 0.
REQ-023 Latency: on the edge that samples the final 1, out_valid SHALL rise, so it is visible in the next cycle.
REQ-024 In Valid, out_valid SHALL stay 1 and in_data SHALL be ignored.
REQ-025 In Valid, in_ack=1 SHALL clear out_valid on that edge and move to Quiet with qctr=0.
REQ-026 in_ack SHALL be ignored whenever out_valid=0.
REQ-027 in_enable=0 in Quiet, GotOne or GotZero SHALL force Quiet with qctr=0, with no out_err and no count change.
REQ-028 in_enable=0 in Valid SHALL have no effect; the ack handshake still completes.
REQ-029 out_busy SHALL be 1 exactly when the state is GotOne or GotZero.
REQ-030 With in_enable=1 and in_data held at 0 indefinitely, qctr SHALL stay at QUIET_MIN with no wrap.

Reset
REQ-031 in_rst=1 on a clock edge SHALL set state=Quiet, qctr=0, out_valid=0, out_err=0, out_busy=0, out_count=0 and out_state=0.
REQ-032 Reset SHALL take priority over in_enable, in_ack and in_data in every state, including mid-pattern and in Valid.
REQ-033 Reset SHALL require no cycles beyond the asserting edge; the block accepts data on the first edge after in_rst falls.

Verification
REQ-034 Scenario: defaults; enable=1; data 0,0,0,0,0,0,1,0,1 -> out_valid=1 the cycle after the last 1; out_count=1; out_busy high for 2 cycles.
REQ-035 Scenario: data 0 x5 then 1,0,1 -> out_valid, out_err and out_busy stay 0; out_count=0.
REQ-036 Scenario: data 0 x6 then 1,1 -> out_err one-cycle pulse; out_state=0.
REQ-037 Scenario: data 0 x6 then 1,0,0 -> out_err pulse; then 0 x5, 1,0,1 is accepted, because qctr restarted at 1.
REQ-038 Scenario: valid pattern, in_ack held low 3 cycles while data toggles -> out_valid stays 1; ack=1 clears it; a second pattern gives out_count=2.
REQ-039 Scenario: CNT_BITS=2, 5 valid patterns each acked -> out_count=3.
REQ-040 Scenario: in_rst pulsed in GotZero -> all outputs 0 next cycle.
REQ-041 Scenario: in_enable dropped in GotOne -> Quiet with no out_err.
